bsg_sha_block_assembler: RTL
============================

BSG_SHA_BLOCK_ASSEMBLER -- requirements
Module: bsg_sha_block_assembler

Interface
REQ-001 The block SHALL have parameter width_p, default 64: bits per input word.
REQ-002 The block SHALL have parameter els_p, default 8: words per assembled block (8 x 64 = one 512-bit SHA-256 message block); legal range is els_p >= 2.
REQ-003 The block SHALL have parameter id_p, default "inv": ring node id, carried for the ring wrapper only and having no functional effect.
REQ-004 The block SHALL use one clock, clk_i; reset_i SHALL be synchronous and active-high.
REQ-005 The block SHALL have port clk_i, input, 1 bit: clock.
REQ-006 The block SHALL have port reset_i, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port en_i, input, 1 bit: input-side enable; when low, ready_o SHALL be 0 and no words SHALL be accepted.
REQ-008 The block SHALL have port v_i, input, 1 bit: input word valid.
REQ-009 The block SHALL have port data_i, input, width_p bits: input word.
REQ-010 The block SHALL have port last_i, input, 1 bit: the current word closes the block early.
REQ-011 The block SHALL have port ready_o, output, 1 bit: a word can be accepted.
REQ-012 The block SHALL have port v_o, output, 1 bit: an assembled block is available.
REQ-013 The block SHALL have port data_o, output, width_p*els_p bits: assembled block, word 0 in bits [width_p-1:0].
REQ-014 The block SHALL have port len_o, output, $clog2(els_p+1) bits: number of valid words in the block, 1..els_p.
REQ-015 The block SHALL have port yumi_i, input, 1 bit: consumer takes the block this cycle; it is legal only while v_o=1.

Function
REQ-016 An input transfer SHALL occur exactly when v_i & ready_o; a word with v_i=1 and ready_o=0 SHALL be ignored and SHALL NOT alter state.
REQ-017 The word accepted in transfer k (k=0..els_p-1) of a block SHALL be written to word slot k.
REQ-018 A block SHALL close on the transfer that fills slot els_p-1, or on a transfer with last_i=1, whichever comes first; last_i SHALL be ignored when v_i & ready_o is 0.
REQ-019 A closed block SHALL record len equal to the number of transfers it received.
REQ-020 data_o word slots with index >= len_o SHALL read as zero, regardless of any stale bank contents.
REQ-021 The block SHALL contain two banks used ping-pong: a fill pointer selects the bank being written and a read pointer selects the bank presented on v_o/data_o/len_o.
REQ-022 An occupancy count of 0..2 full banks SHALL be maintained.
REQ-023 A block closing at cycle t SHALL cause v_o=1 at cycle t+1, provided no earlier block is still pending; latency is 1 cycle.
REQ-024 ready_o SHALL equal en_i & (occupancy < 2); filling SHALL continue into the other bank in the cycle after a close, giving a sustained throughput of 1 word per cycle.
REQ-025 v_o SHALL be 1 exactly when occupancy > 0; data_o and len_o SHALL remain stable while v_o=1 and yumi_i=0.
REQ-026 On yumi_i the read pointer SHALL toggle and occupancy SHALL decrement.
REQ-027 When a block closes and yumi_i is asserted in the same cycle, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-028 When occupancy=2, ready_o SHALL be 0; a yumi_i in that state SHALL make ready_o=1 in the next cycle, not combinationally.
REQ-029 Both the word counter (0..els_p-1) and the pointers SHALL wrap to 0 after a close.
REQ-030 Deasserting en_i mid-block SHALL preserve the word counter and partial contents; the output side SHALL remain operational while en_i=0.

Reset
REQ-031 While reset_i=1: ready_o=0, v_o=0, len_o=0, occupancy=0, both pointers=0, word counter=0.
REQ-032 A reset asserted mid-block SHALL discard partial and pending blocks.
REQ-033 Bank data registers SHALL NOT be reset; REQ-020 guarantees data_o correctness.
REQ-034 ready_o SHALL follow REQ-024 from the first cycle after reset_i falls.

Structure
REQ-035 Package bsg_sha_pkg SHALL hold the SHA-256 block constants (block bits 512, word bits) and the default els_p.
REQ-036 One sub-module, bsg_sha_asm_bank, SHALL implement one bank: els_p word registers with per-slot write enable, a len register, and zero-masking of the output.
REQ-037 The top level SHALL instantiate two bsg_sha_asm_bank plus the counter, pointer, and occupancy logic, built on bsg_dff_reset / bsg_dff_en.

Verification (width_p=64, els_p=4)
REQ-038 Feed 4 back-to-back words 0x11..0x44 with yumi_i tied 1 -> v_o=1 for one cycle after word 4, data_o={0x44,0x33,0x22,0x11}, len_o=4.
REQ-039 Feed 0xA, then 0xB with last_i=1 -> len_o=2, data_o={0,0,0xB,0xA}, and the upper slots are zero even after a previous full block.
REQ-040 Feed 12 continuous words with yumi_i=0 -> ready_o drops after word 8, blocks 1 and 2 are held, and ready_o rises 1 cycle after the first yumi_i.
REQ-041 Close a block in the same cycle as yumi_i of the prior block -> occupancy stays 1 and data_o switches to the new block next cycle.
REQ-042 Reset after 2 words, then feed 4 words -> the first block out contains only the post-reset words.
REQ-043 Drop en_i for 5 cycles after word 2 while v_i=1 -> no words accepted, and the block completes correctly when en_i returns.

Source files
------------

// File: rtl/bsg_sha_pkg.sv
// Shared SHA-256 block-assembly constants: message block geometry and the
// default input word width / words-per-block used by the assembler.
package bsg_sha_pkg;

    localparam int sha_block_bits_lp  = 512;
    localparam int sha_word_bits_lp   = 32;
    localparam int sha_in_width_lp    = 2 * sha_word_bits_lp;
    localparam int sha_default_els_lp = sha_block_bits_lp / sha_in_width_lp;

endpackage

// File: rtl/bsg_dff_en.sv
// Plain register with load enable and no reset.
module bsg_dff_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_dff_reset.sv
// Plain register with synchronous active-high reset to zero.
module bsg_dff_reset #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_sha_asm_bank.sv
// One assembly bank: els_p word slots with per-slot write enable, a length
// register, and output masking so slots at or beyond the length read as zero.
module bsg_sha_asm_bank
    import bsg_sha_pkg::*;
#(
    parameter int width_p = sha_in_width_lp,
    parameter int els_p   = sha_default_els_lp
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         we_i,
    input  logic [$clog2(els_p)-1:0]     slot_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         close_i,
    input  logic [$clog2(els_p+1)-1:0]   len_i,
    output logic [width_p*els_p-1:0]     data_o,
    output logic [$clog2(els_p+1)-1:0]   len_o
);

    localparam int cnt_w_lp = $clog2(els_p);
    localparam int len_w_lp = $clog2(els_p+1);

    logic [len_w_lp-1:0] len_d;
    logic [len_w_lp-1:0] len_q;

    always_comb begin
        len_d = len_q;
        if (close_i) begin
            len_d = len_i;
        end
    end

    bsg_dff_reset #(.width_p(len_w_lp)) len_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (len_d),
        .data_o  (len_q)
    );

    // Word storage is never reset; the length mask hides stale contents.
    for (genvar i = 0; i < els_p; i++) begin : g_slot
        logic               slot_we;
        logic [width_p-1:0] word_q;

        assign slot_we = we_i & (slot_i == cnt_w_lp'(i));

        bsg_dff_en #(.width_p(width_p)) word_reg (
            .clk_i  (clk_i),
            .en_i   (slot_we),
            .data_i (data_i),
            .data_o (word_q)
        );

        assign data_o[i*width_p +: width_p] = (len_w_lp'(i) < len_q) ? word_q : '0;
    end

    assign len_o = len_q;

endmodule

// File: rtl/bsg_sha_block_assembler.sv
// Packs a stream of width_p-bit words into els_p-word blocks using two
// ping-pong banks, so filling continues while a finished block waits.
module bsg_sha_block_assembler
    import bsg_sha_pkg::*;
#(
    parameter int width_p = sha_in_width_lp,
    parameter int els_p   = sha_default_els_lp,
    parameter     id_p    = "inv"
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         en_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         last_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [width_p*els_p-1:0]     data_o,
    output logic [$clog2(els_p+1)-1:0]   len_o,
    input  logic                         yumi_i
);

    localparam int cnt_w_lp = $clog2(els_p);
    localparam int len_w_lp = $clog2(els_p+1);

    logic [cnt_w_lp-1:0] wr_cnt_d, wr_cnt_q;
    logic                fill_ptr_d, fill_ptr_q;
    logic                rd_ptr_d, rd_ptr_q;
    logic [1:0]          occ_d, occ_q;

    logic                xfer;
    logic                last_slot;
    logic                close_blk;
    logic                yumi;
    logic [len_w_lp-1:0] close_len;

    logic [width_p*els_p-1:0] bank_data [2];
    logic [len_w_lp-1:0]      bank_len  [2];

    // Handshake: a word moves when v_i & ready_o; a block leaves on yumi_i,
    // which is only honoured while v_o is high.
    assign ready_o = ~reset_i & en_i & (occ_q != 2'd2);
    assign v_o     = ~reset_i & (occ_q != 2'd0);

    always_comb begin
        xfer       = v_i & ready_o;
        last_slot  = (wr_cnt_q == cnt_w_lp'(els_p - 1));
        close_blk  = xfer & (last_i | last_slot);
        yumi       = yumi_i & v_o;
        close_len  = len_w_lp'(wr_cnt_q) + len_w_lp'(1);

        wr_cnt_d = wr_cnt_q;
        if (close_blk) begin
            wr_cnt_d = '0;
        end else if (xfer) begin
            wr_cnt_d = wr_cnt_q + cnt_w_lp'(1);
        end

        fill_ptr_d = fill_ptr_q ^ close_blk;
        rd_ptr_d   = rd_ptr_q ^ yumi;
        occ_d      = occ_q + {1'b0, close_blk} - {1'b0, yumi};
    end

    bsg_dff_reset #(.width_p(cnt_w_lp)) wr_cnt_reg (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(wr_cnt_d), .data_o(wr_cnt_q)
    );

    bsg_dff_reset #(.width_p(1)) fill_ptr_reg (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(fill_ptr_d), .data_o(fill_ptr_q)
    );

    bsg_dff_reset #(.width_p(1)) rd_ptr_reg (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(rd_ptr_d), .data_o(rd_ptr_q)
    );

    bsg_dff_reset #(.width_p(2)) occ_reg (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(occ_d), .data_o(occ_q)
    );

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic sel;
        assign sel = (fill_ptr_q == 1'(b));

        bsg_sha_asm_bank #(.width_p(width_p), .els_p(els_p)) bank (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .we_i    (xfer & sel),
            .slot_i  (wr_cnt_q),
            .data_i  (data_i),
            .close_i (close_blk & sel),
            .len_i   (close_len),
            .data_o  (bank_data[b]),
            .len_o   (bank_len[b])
        );
    end

    assign data_o = bank_data[rd_ptr_q];
    assign len_o  = v_o ? bank_len[rd_ptr_q] : '0;

endmodule
